// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with a write-back
// scoreboard tracking outstanding producers per architectural register.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  we,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       write_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_count
);

    localparam int CW = AW + 1;

    // x0 has no storage; it is synthesised as a constant zero on read.
    logic [XLEN-1:0]  r_rf [1:NREGS-1];
    logic [NREGS-1:1] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic [NREGS-1:1] w_busy_nxt;
    logic [CW-1:0]    w_busy_pop;

    assign w_wr_ok  = we && (rd != '0);
    assign w_rsv_ok = rsv_en && (rsv_addr != '0) && !flush;

    // Next busy vector: flush beats a new reservation, which beats a write-back clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (w_wr_ok && (rd == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_rsv_ok && (rsv_addr == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
    end

    // Population count of the next busy vector, so the registered count tracks r_busy.
    always_comb begin
        w_busy_pop = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_busy_pop = w_busy_pop + CW'(w_busy_nxt[i]);
        end
    end

    // Register storage: write-back lands even under flush; x0 writes are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rd == AW'(i)) begin
                    r_rf[i] <= write_data;
                end
            end
        end
    end

    // Scoreboard state and its registered occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_pop;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_byp;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = rs_addr[gp*AW +: AW];
        assign w_byp  = (BYPASS != 0) && w_wr_ok && (rd == w_addr);

        // Read mux: x0 and reset give zero; a same-cycle write-back is forwarded and not busy.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (w_addr == AW'(i)) begin
                    w_data = r_rf[i];
                    w_busy = r_busy[i];
                end
            end
            if (w_byp) begin
                w_data = write_data;
                w_busy = 1'b0;
            end
            if (reset) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rs_data[gp*XLEN +: XLEN] = w_data;
        assign rs_busy[gp]              = w_busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors for reg_file_sb, with a bypassing
// instance and a non-bypassing instance driven by identical stimulus.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic                 clk;
    logic                 reset;
    logic [NRD*AW-1:0]    rs_addr;
    logic                 we;
    logic [AW-1:0]        rd;
    logic [XLEN-1:0]      write_data;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic                 flush;

    logic [NRD*XLEN-1:0]  d1;
    logic [NRD-1:0]       b1;
    logic [AW:0]          c1;
    logic [NRD*XLEN-1:0]  d0;
    logic [NRD-1:0]       b0;
    logic [AW:0]          c0;

    int n_chk = 0;
    int n_fail = 0;

    reg_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset), .rs_addr(rs_addr),
        .rs_data(d1), .rs_busy(b1), .we(we), .rd(rd),
        .write_data(write_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_count(c1)
    );

    reg_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .reset(reset), .rs_addr(rs_addr),
        .rs_data(d0), .rs_busy(b0), .we(we), .rd(rd),
        .write_data(write_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_count(c0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [5:0]  cnt;
        logic [31:0] nd0;
        logic        nb0;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; rd = '0; write_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " d1"}, 64'(d1), 64'd0);
        chk({tag, " b1"}, 64'(b1), 64'd0);
        chk({tag, " c1"}, 64'(c1), 64'd0);
        chk({tag, " d0"}, 64'(d0), 64'd0);
        chk({tag, " b0"}, 64'(b0), 64'd0);
        chk({tag, " c0"}, 64'(c0), 64'd0);
    endtask

    initial begin
        //         we rd  wd            rsv ra fl a0 a1  d0            d1            b0 b1 cnt nd0          nb0
        vt[0]  = '{0, 0,  32'h0,        0,  0, 0, 0, 31, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
        vt[1]  = '{1, 5,  32'hDEADBEEF, 0,  0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0};
        vt[2]  = '{1, 0,  32'h1234,     1,  0, 0, 0, 5,  32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0,        0};
        vt[3]  = '{0, 0,  32'h0,        1,  7, 0, 7, 0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
        vt[4]  = '{1, 7,  32'h77,       1,  7, 0, 7, 5,  32'h77,       32'hDEADBEEF, 0, 0, 1, 32'h0,        1};
        vt[5]  = '{0, 0,  32'h0,        0,  0, 0, 7, 7,  32'h77,       32'h77,       1, 1, 1, 32'h77,       1};
        vt[6]  = '{1, 7,  32'h78,       0,  0, 0, 0, 7,  32'h0,        32'h78,       0, 0, 1, 32'h0,        0};
        vt[7]  = '{0, 0,  32'h0,        0,  0, 0, 7, 7,  32'h78,       32'h78,       0, 0, 0, 32'h78,       0};
        vt[8]  = '{0, 0,  32'h0,        1,  1, 0, 1, 2,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0};
        vt[9]  = '{0, 0,  32'h0,        1,  2, 0, 1, 2,  32'h0,        32'h0,        1, 0, 1, 32'h0,        1};
        vt[10] = '{0, 0,  32'h0,        1,  3, 0, 2, 3,  32'h0,        32'h0,        1, 0, 2, 32'h0,        1};
        vt[11] = '{1, 3,  32'h33,       1,  4, 1, 3, 4,  32'h33,       32'h0,        0, 0, 3, 32'h0,        1};
        vt[12] = '{0, 0,  32'h0,        0,  0, 0, 3, 4,  32'h33,       32'h0,        0, 0, 0, 32'h33,       0};
        vt[13] = '{1, 9,  32'h55,       1,  9, 0, 9, 0,  32'h55,       32'h0,        0, 0, 0, 32'h0,        0};
        vt[14] = '{0, 0,  32'h0,        0,  0, 0, 9, 9,  32'h55,       32'h55,       1, 1, 1, 32'h55,       1};

        reset = 1'b1;
        rs_addr = '0;
        idle();
        #2;
        all_zero("reset held");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < NREGS; a++) begin
            rs_addr = {5'(a), 5'(NREGS - 1 - a)};
            #1;
            chk($sformatf("post-reset rd x%0d", a),
                {d1[63:32], d0[31:0]}, 64'd0);
            chk($sformatf("post-reset busy x%0d", a),
                64'({b1, b0}), 64'd0);
        end
        chk("post-reset cnt", 64'(c1), 64'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            we = vt[i].we; rd = vt[i].rd; write_data = vt[i].wd;
            rsv_en = vt[i].rsv; rsv_addr = vt[i].ra; flush = vt[i].fl;
            rs_addr = {vt[i].a1, vt[i].a0};
            #1;
            chk($sformatf("v%0d d0", i), 64'(d1[31:0]), 64'(vt[i].d0));
            chk($sformatf("v%0d d1", i), 64'(d1[63:32]), 64'(vt[i].d1));
            chk($sformatf("v%0d b0", i), 64'(b1[0]), 64'(vt[i].b0));
            chk($sformatf("v%0d b1", i), 64'(b1[1]), 64'(vt[i].b1));
            chk($sformatf("v%0d cnt", i), 64'(c1), 64'(vt[i].cnt));
            chk($sformatf("v%0d nb d0", i), 64'(d0[31:0]), 64'(vt[i].nd0));
            chk($sformatf("v%0d nb b0", i), 64'(b0[0]), 64'(vt[i].nb0));
            chk($sformatf("v%0d nb cnt", i), 64'(c0), 64'(vt[i].cnt));
        end

        // Async reset mid-cycle with x9 busy and holding 0x55, plus a write in flight.
        @(negedge clk);
        idle();
        rs_addr = {5'd9, 5'd9};
        #1;
        chk("pre-reset x9 data", 64'(d1[31:0]), 64'h55);
        chk("pre-reset x9 busy", 64'(b1[0]), 64'd1);
        #1;
        we = 1'b1; rd = 5'd9; write_data = 32'hAA;
        rsv_en = 1'b1; rsv_addr = 5'd10;
        reset = 1'b1;
        #1;
        all_zero("async reset");
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        all_zero("after release x9");
        rs_addr = {5'd5, 5'd10};
        #1;
        all_zero("after release x5/x10");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
